hex_display_controller: RTL and testbench

//  Multi-channel 7-segment result display for board-level tops.
//  - Captures up to NUM_CHANNELS result words into snapshot registers and shows one channel at a time.
//  - The channel is either picked by switches or auto-rotated on a timer; a freeze input holds all snapshots.
//  - Sits between compute cores (cycle counters, matrix sums, ...) and the HEX outputs.

---
 rtl/hex_display_pkg.sv | 34 +++
 rtl/hex_digit_encoder.sv | 21 ++
 rtl/hex_display_controller.sv | 122 ++++++++++++
 tb/tb_hex_display_controller.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/hex_display_pkg.sv
// Shared types, segment constants and the hex-to-7-segment encoder for the
// multi-channel hex display controller.
package hex_display_pkg;

   typedef enum logic {MANUAL, AUTO} disp_mode_t;

   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [6:0] SEG_DASH  = 7'b0111111;

   // Active-low segments, bit0=a .. bit6=g
   function automatic logic [6:0] seg_encode(input logic [3:0] nib);
      logic [6:0] seg;
      case (nib)
         4'h0:    seg = 7'b1000000;
         4'h1:    seg = 7'b1111001;
         4'h2:    seg = 7'b0100100;
         4'h3:    seg = 7'b0110000;
         4'h4:    seg = 7'b0011001;
         4'h5:    seg = 7'b0010010;
         4'h6:    seg = 7'b0000010;
         4'h7:    seg = 7'b1111000;
         4'h8:    seg = 7'b0000000;
         4'h9:    seg = 7'b0010000;
         4'hA:    seg = 7'b0001000;
         4'hB:    seg = 7'b0000011;
         4'hC:    seg = 7'b1000110;
         4'hD:    seg = 7'b0100001;
         4'hE:    seg = 7'b0000110;
         default: seg = 7'b0001110;
      endcase
      return seg;
   endfunction

endpackage

// File: rtl/hex_digit_encoder.sv
// One display digit: nibble plus blank/dash overrides to active-low segments.
// Dash has priority over blank, blank over the hex glyph.
module hex_digit_encoder
   import hex_display_pkg::*;
(
   input  logic [3:0] nibble_i,
   input  logic       blank_i,
   input  logic       dash_i,
   output logic [6:0] seg_o
);

   always_comb begin
      if (dash_i)
         seg_o = SEG_DASH;
      else if (blank_i)
         seg_o = SEG_BLANK;
      else
         seg_o = seg_encode(nibble_i);
   end

endmodule

// File: rtl/hex_display_controller.sv
// Multi-channel snapshot display with manual/auto channel selection and freeze.
// Optional macro LEADING_ZERO_BLANK_EN darkens zero digits above the top non-zero one.
module hex_display_controller
   import hex_display_pkg::*;
#(
   parameter int NUM_DIGITS    = 6,
   parameter int NUM_CHANNELS  = 4,
   parameter int ROTATE_CYCLES = 25_000_000
) (
   input  logic                                      CLOCK_50,
   input  logic                                      reset,
   input  logic [NUM_CHANNELS-1:0][4*NUM_DIGITS-1:0] ch_data,
   input  logic [NUM_CHANNELS-1:0]                   ch_valid,
   input  logic [$clog2(NUM_CHANNELS)-1:0]           sel,
   input  logic                                      auto_rotate,
   input  logic                                      freeze,
   output logic [NUM_DIGITS-1:0][6:0]                hex_out,
   output logic [$clog2(NUM_CHANNELS)-1:0]           cur_channel,
   output logic [NUM_CHANNELS-1:0]                   ch_loaded
);

   localparam int CH_W  = $clog2(NUM_CHANNELS);
   localparam int CNT_W = $clog2(ROTATE_CYCLES);

   logic [NUM_CHANNELS-1:0][4*NUM_DIGITS-1:0] snap_q;
   logic [NUM_CHANNELS-1:0]                   loaded_q;
   disp_mode_t                                state_q;
   logic [CH_W-1:0]                           cur_channel_q;
   logic [CNT_W-1:0]                          rot_cnt_q;
   logic [NUM_DIGITS-1:0][6:0]                hex_q;
   logic [NUM_DIGITS-1:0][6:0]                seg_d;
   logic [4*NUM_DIGITS-1:0]                   word_sel;
   logic                                      dash_sel;
   logic [NUM_DIGITS-1:0]                     blank_d;

   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         snap_q   <= '0;
         loaded_q <= '0;
      end else if (!freeze) begin
         for (int i = 0; i < NUM_CHANNELS; i++) begin
            if (ch_valid[i]) begin
               snap_q[i]   <= ch_data[i];
               loaded_q[i] <= 1'b1;
            end
         end
      end
   end

   // Mode FSM; the mode-change cycle itself always holds cur_channel
   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         state_q       <= MANUAL;
         cur_channel_q <= '0;
         rot_cnt_q     <= '0;
      end else begin
         case (state_q)
            MANUAL: begin
               if (auto_rotate) begin
                  state_q   <= AUTO;
                  rot_cnt_q <= '0;
               end else if (int'(sel) < NUM_CHANNELS) begin
                  cur_channel_q <= sel;
               end
            end
            AUTO: begin
               if (!auto_rotate) begin
                  state_q <= MANUAL;
               end else if (rot_cnt_q == CNT_W'(ROTATE_CYCLES - 1)) begin
                  rot_cnt_q <= '0;
                  if (cur_channel_q == CH_W'(NUM_CHANNELS - 1))
                     cur_channel_q <= '0;
                  else
                     cur_channel_q <= cur_channel_q + CH_W'(1);
               end else begin
                  rot_cnt_q <= rot_cnt_q + CNT_W'(1);
               end
            end
            default: state_q <= MANUAL;
         endcase
      end
   end

   assign word_sel = snap_q[cur_channel_q];
   assign dash_sel = ~loaded_q[cur_channel_q];

   always_comb begin
      blank_d = '0;
`ifdef LEADING_ZERO_BLANK_EN
      begin : lz_scan
         logic nz;
         nz = 1'b0;
         for (int d = NUM_DIGITS - 1; d > 0; d--) begin
            if (word_sel[4*d +: 4] != 4'h0)
               nz = 1'b1;
            blank_d[d] = ~nz;
         end
      end
`endif
   end

   for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
      hex_digit_encoder u_enc (
         .nibble_i (word_sel[4*g +: 4]),
         .blank_i  (blank_d[g]),
         .dash_i   (dash_sel),
         .seg_o    (seg_d[g])
      );
   end

   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset)
         hex_q <= {NUM_DIGITS{SEG_BLANK}};
      else
         hex_q <= seg_d;
   end

   assign hex_out     = hex_q;
   assign cur_channel = cur_channel_q;
   assign ch_loaded   = loaded_q;

endmodule

// File: tb/tb_hex_display_controller.sv
// Directed bench for hex_display_controller (6 digits, 4 channels, 4-clock rotation).
module tb_hex_display_controller;

   localparam logic [6:0] S0 = 7'h40, S1 = 7'h79, S2 = 7'h24, S3 = 7'h30;
   localparam logic [6:0] S4 = 7'h19, S5 = 7'h12, S6 = 7'h02, S9 = 7'h10;
   localparam logic [6:0] SA = 7'h08, SB = 7'h03, SC = 7'h46, SD = 7'h21;
   localparam logic [6:0] SE = 7'h06, SF = 7'h0E;
   localparam logic [6:0] DSH = 7'h3F, BLK = 7'h7F;

   logic                 CLOCK_50 = 1'b0;
   logic                 reset;
   logic [3:0][23:0]     ch_data;
   logic [3:0]           ch_valid;
   logic [1:0]           sel;
   logic                 auto_rotate;
   logic                 freeze;
   logic [5:0][6:0]      hex_out;
   logic [1:0]           cur_channel;
   logic [3:0]           ch_loaded;

   int checks = 0;
   int errors = 0;
   logic [5:0][6:0] exp_hex;
   logic [1:0]      rot_exp [13] = '{2'd3, 2'd3, 2'd3, 2'd3, 2'd0, 2'd0, 2'd0, 2'd0,
                                     2'd1, 2'd1, 2'd1, 2'd1, 2'd2};

   hex_display_controller #(
      .NUM_DIGITS    (6),
      .NUM_CHANNELS  (4),
      .ROTATE_CYCLES (4)
   ) dut (
      .CLOCK_50    (CLOCK_50),
      .reset       (reset),
      .ch_data     (ch_data),
      .ch_valid    (ch_valid),
      .sel         (sel),
      .auto_rotate (auto_rotate),
      .freeze      (freeze),
      .hex_out     (hex_out),
      .cur_channel (cur_channel),
      .ch_loaded   (ch_loaded)
   );

   always #5 CLOCK_50 = ~CLOCK_50;

   task automatic tick();
      @(posedge CLOCK_50);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      reset       = 1'b1;
      ch_data     = '0;
      ch_valid    = '0;
      sel         = 2'd0;
      auto_rotate = 1'b0;
      freeze      = 1'b0;
      tick();
      tick();
      chk("rst_hex", 64'(hex_out), 64'({6{BLK}}));
      chk("rst_cur", 64'(cur_channel), 64'd0);
      chk("rst_loaded", 64'(ch_loaded), 64'd0);
      reset = 1'b0;
      tick();
      chk("post_rst_dash", 64'(hex_out), 64'({6{DSH}}));

      // capture 00A5C3 on channel 2 and select it
      ch_data[2]  = 24'h00A5C3;
      ch_valid[2] = 1'b1;
      sel         = 2'd2;
      tick();
      ch_valid = '0;
      tick();
`ifdef LEADING_ZERO_BLANK_EN
      exp_hex = {BLK, BLK, SA, S5, SC, S3};
`else
      exp_hex = {S0, S0, SA, S5, SC, S3};
`endif
      chk("ch2_hex", 64'(hex_out), 64'(exp_hex));
      chk("ch2_loaded", 64'(ch_loaded), 64'b0100);
      chk("ch2_cur", 64'(cur_channel), 64'd2);

      // auto rotation from channel 3, sel toggling ignored
      sel = 2'd3;
      tick();
      chk("sel3_cur", 64'(cur_channel), 64'd3);
      auto_rotate = 1'b1;
      for (int k = 0; k < 13; k++) begin
         tick();
         sel = (k % 2 == 0) ? 2'd1 : 2'd2;
         chk($sformatf("rot_%0d", k), 64'(cur_channel), 64'(rot_exp[k]));
      end

      // back to manual with sel=1 (channel 1 never loaded)
      auto_rotate = 1'b0;
      sel         = 2'd1;
      tick();
      chk("man_hold", 64'(cur_channel), 64'd2);
      tick();
      chk("man_sel1", 64'(cur_channel), 64'd1);
      tick();
      chk("ch1_dash", 64'(hex_out), 64'({6{DSH}}));

      // freeze beats a simultaneous capture
      sel = 2'd0;
      tick();
      freeze      = 1'b1;
      ch_data[0]  = 24'h123456;
      ch_valid[0] = 1'b1;
      tick();
      freeze   = 1'b0;
      ch_valid = '0;
      tick();
      chk("frz_loaded", 64'(ch_loaded), 64'b0100);
      chk("frz_dash", 64'(hex_out), 64'({6{DSH}}));
      ch_valid[0] = 1'b1;
      tick();
      ch_valid = '0;
      tick();
      chk("ch0_hex", 64'(hex_out), 64'({S1, S2, S3, S4, S5, S6}));
      chk("ch0_loaded", 64'(ch_loaded), 64'b0101);

      // simultaneous capture: zero on channel 1, FEDCB9 on channel 3
      ch_data[1] = 24'h000000;
      ch_data[3] = 24'hFEDCB9;
      ch_valid   = 4'b1010;
      sel        = 2'd1;
      tick();
      ch_valid = '0;
      tick();
`ifdef LEADING_ZERO_BLANK_EN
      exp_hex = {BLK, BLK, BLK, BLK, BLK, S0};
`else
      exp_hex = {6{S0}};
`endif
      chk("ch1_zero", 64'(hex_out), 64'(exp_hex));
      chk("multi_loaded", 64'(ch_loaded), 64'b1111);
      sel = 2'd3;
      tick();
      tick();
      chk("ch3_hex", 64'(hex_out), 64'({SF, SE, SD, SC, SB, S9}));

      // asynchronous reset mid-rotation
      auto_rotate = 1'b1;
      tick();
      tick();
      #2;
      reset = 1'b1;
      #1;
      chk("arst_hex", 64'(hex_out), 64'({6{BLK}}));
      chk("arst_cur", 64'(cur_channel), 64'd0);
      chk("arst_loaded", 64'(ch_loaded), 64'd0);
      auto_rotate = 1'b0;
      sel         = 2'd0;
      tick();
      reset = 1'b0;
      tick();
      chk("arst_dash", 64'(hex_out), 64'({6{DSH}}));
      chk("arst_cur2", 64'(cur_channel), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
